// File: rtl/timer_pkg.sv
// Shared widths, digit limits and the BCD digit type for the countdown timer.
package timer_pkg;
    localparam int BCD_W        = 4;
    localparam int DIGIT_MAX    = 9;
    localparam int SEC_TENS_MAX = 5;

    typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit: shift-load from the neighbour, decrement on borrow,
// wrap from 0 to MAX, and report its own zero state for the borrow chain.
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter int MAX = DIGIT_MAX
) (
    input  logic clk,
    input  logic clrn,
    input  logic shift_en,
    input  bcd_t shift_in,
    input  logic dec_en,
    input  logic borrow_in,
    output bcd_t q,
    output logic borrow_out,
    output logic is_zero
);
    bcd_t q_reg;
    bcd_t q_next;

    assign is_zero    = (q_reg == '0);
    assign borrow_out = borrow_in & is_zero;
    assign q          = q_reg;

    // A keypad value above MAX still counts down plainly; only a wrap reloads MAX.
    always_comb begin
        q_next = q_reg;
        if (shift_en) begin
            q_next = shift_in;
        end else if (dec_en && borrow_in) begin
            q_next = is_zero ? bcd_t'(MAX) : q_reg - bcd_t'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end
endmodule

// File: rtl/countdown_timer_bcd.sv
// Keypad-loaded BCD minutes:seconds countdown with a one-cycle done pulse.
// Leading-zero blanking is built only when TIMER_LZB_EN is defined.
module countdown_timer_bcd
    import timer_pkg::*;
#(
    parameter  int MIN_DIGITS = 1,
    localparam int ND         = MIN_DIGITS + 2
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [BCD_W-1:0]    data,
    input  logic                loadn,
    input  logic                enable,
    input  logic                tick,
    output logic [BCD_W*ND-1:0] digits_out,
    output logic [ND-1:0]       blank,
    output logic                zero,
    output logic                done
);
    bcd_t          digit_q [ND];
    logic          borrow  [ND+1];
    logic [ND-1:0] is_zero;
    logic [ND-1:0] upper_zero;
    logic          load_ok;
    logic          dec;
    logic          done_reg;
    logic          done_next;

    // Invalid keypad codes leave every digit untouched.
    assign load_ok   = !loadn && (data <= bcd_t'(DIGIT_MAX));
    assign borrow[0] = 1'b1;
    // The borrow chain running out of digits means the count is already 0:0.
    assign dec       = loadn && enable && tick && !borrow[ND];

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_digit
            localparam int DMAX = (gi == 1) ? SEC_TENS_MAX : DIGIT_MAX;
            bcd_t shift_in;

            if (gi == 0) begin : g_first
                assign shift_in = data;
            end else begin : g_rest
                assign shift_in = digit_q[gi-1];
            end

            bcd_digit_down #(
                .MAX(DMAX)
            ) u_digit (
                .clk       (clk),
                .clrn      (clrn),
                .shift_en  (load_ok),
                .shift_in  (shift_in),
                .dec_en    (dec),
                .borrow_in (borrow[gi]),
                .q         (digit_q[gi]),
                .borrow_out(borrow[gi+1]),
                .is_zero   (is_zero[gi])
            );

            assign digits_out[gi*BCD_W +: BCD_W] = digit_q[gi];
        end
    endgenerate

    // upper_zero[i]: digit i and everything more significant are zero.
    always_comb begin
        upper_zero         = '0;
        upper_zero[ND-1]   = is_zero[ND-1];
        for (int i = ND - 2; i >= 0; i--) begin
            upper_zero[i] = is_zero[i] & upper_zero[i+1];
        end
    end

    assign zero = upper_zero[0];

    // The count lands on zero exactly when a decrement is applied to ..0:01.
    assign done_next = dec && upper_zero[1] && (digit_q[0] == bcd_t'(1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= done_next;
        end
    end

    assign done = done_reg;

`ifdef TIMER_LZB_EN
    assign blank = upper_zero;
`else
    assign blank = '0;
`endif
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd: one instance with one minute digit and one with two.
module tb_countdown_timer_bcd;
    logic        clk    = 1'b0;
    logic        clrn   = 1'b1;
    logic [3:0]  data   = 4'd0;
    logic        loadn  = 1'b1;
    logic        enable = 1'b0;
    logic        tick   = 1'b0;

    logic [11:0] d1;
    logic [2:0]  b1;
    logic        z1;
    logic        dn1;
    logic [15:0] d2;
    logic [3:0]  b2;
    logic        z2;
    logic        dn2;

    int n_vec = 0;
    int n_err = 0;
    int pulses;

    always #5 clk = ~clk;

    countdown_timer_bcd #(.MIN_DIGITS(1)) u_dut1 (
        .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .enable(enable), .tick(tick),
        .digits_out(d1), .blank(b1), .zero(z1), .done(dn1)
    );

    countdown_timer_bcd #(.MIN_DIGITS(2)) u_dut2 (
        .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .enable(enable), .tick(tick),
        .digits_out(d2), .blank(b2), .zero(z2), .done(dn2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Expected blank vector: a digit blanks when it and all higher digits are zero.
    function automatic logic [3:0] lzb(input logic [15:0] v, input int nd);
        logic [3:0] b;
        logic       run;
        b   = '0;
        run = 1'b1;
        for (int i = nd - 1; i >= 0; i--) begin
            run  = run && (v[i*4 +: 4] == 4'd0);
            b[i] = run;
        end
`ifdef TIMER_LZB_EN
        return b;
`else
        return 4'd0;
`endif
    endfunction

    task automatic check_state(input string tag, input logic [11:0] e1, input logic [15:0] e2);
        chk({tag, ".d1"}, 32'(d1), 32'(e1));
        chk({tag, ".d2"}, 32'(d2), 32'(e2));
        chk({tag, ".z1"}, 32'(z1), 32'(e1 == 12'h000));
        chk({tag, ".z2"}, 32'(z2), 32'(e2 == 16'h0000));
        chk({tag, ".b1"}, 32'(b1), 32'(lzb({4'h0, e1}, 3)));
        chk({tag, ".b2"}, 32'(b2), 32'(lzb(e2, 4)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] d);
        data  = d;
        loadn = 1'b0;
        step();
        loadn = 1'b1;
    endtask

    task automatic run_ticks(input int n, output int p);
        p    = 0;
        tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (dn1) p++;
        end
        tick = 1'b0;
    endtask

    initial begin
        // Asynchronous reset with no clock edge needed
        #1 clrn = 1'b0;
        #2;
        check_state("reset", 12'h000, 16'h0000);
        chk("reset.done1", 32'(dn1), 32'd0);
        chk("reset.done2", 32'(dn2), 32'd0);
        @(posedge clk);
        #3 clrn = 1'b1;

        // Keypad entry 1,2,3 then count 83 seconds down to zero
        load(4'd1); load(4'd2); load(4'd3);
        check_state("load123", 12'h123, 16'h0123);
        enable = 1'b1;
        run_ticks(83, pulses);
        check_state("count83", 12'h000, 16'h0000);
        chk("count83.pulses", 32'(pulses), 32'd1);
        chk("count83.done1", 32'(dn1), 32'd1);
        chk("count83.done2", 32'(dn2), 32'd1);
        step();
        chk("count83.done1_off", 32'(dn1), 32'd0);

        // Tick while at zero: hold, no done
        run_ticks(1, pulses);
        check_state("tick_at_zero", 12'h000, 16'h0000);
        chk("tick_at_zero.pulses", 32'(pulses), 32'd0);

        // Seconds-tens digit above 5 counts through, then wraps to 5
        load(4'd9); load(4'd9);
        check_state("load99", 12'h099, 16'h0099);
        run_ticks(40, pulses);
        check_state("tick40", 12'h059, 16'h0059);
        chk("tick40.pulses", 32'(pulses), 32'd0);
        run_ticks(1, pulses);
        check_state("tick41", 12'h058, 16'h0058);

        // Invalid digit 12 between 4 and 5
        load(4'd0); load(4'd4);
        check_state("load04", 12'h804, 16'h5804);
        load(4'd12);
        check_state("load_invalid", 12'h804, 16'h5804);
        load(4'd5);
        check_state("load5", 12'h045, 16'h8045);

        // Overflowing the digit count drops the oldest digit
        load(4'd1); load(4'd2); load(4'd3); load(4'd4);
        check_state("load1234", 12'h234, 16'h1234);

        // Paused: ticks ignored
        enable = 1'b0;
        run_ticks(3, pulses);
        check_state("paused", 12'h234, 16'h1234);

        // Load and tick together: shift only
        enable = 1'b1;
        tick   = 1'b1;
        load(4'd5);
        tick   = 1'b0;
        check_state("load_and_tick", 12'h345, 16'h2345);

        // Loading to all zero never raises done
        load(4'd0); load(4'd0); load(4'd0); load(4'd0);
        check_state("load_zero", 12'h000, 16'h0000);
        chk("load_zero.done1", 32'(dn1), 32'd0);
        step();
        chk("load_zero.done1_next", 32'(dn1), 32'd0);

        // Asynchronous reset in the middle of a count at 1:07
        load(4'd1); load(4'd0); load(4'd8);
        run_ticks(1, pulses);
        check_state("at107", 12'h107, 16'h0107);
        @(posedge clk);
        #3 clrn = 1'b0;
        #1;
        check_state("async_rst", 12'h000, 16'h0000);
        chk("async_rst.done1", 32'(dn1), 32'd0);
        step();
        step();
        chk("async_rst.done1_hold", 32'(dn1), 32'd0);
        chk("async_rst.done2_hold", 32'(dn2), 32'd0);
        #2 clrn = 1'b1;
        load(4'd4);
        check_state("after_rst", 12'h004, 16'h0004);

        // Borrow from the minutes through the seconds-tens wrap
        load(4'd1); load(4'd0); load(4'd0);
        check_state("load100", 12'h100, 16'h4100);
        run_ticks(1, pulses);
        check_state("borrow", 12'h059, 16'h4059);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
